// File: rtl/tpu_pkg.sv
// Shared TPU definitions: array geometry defaults, datapath width and the
// controller state encoding used by the systolic array sequencer.
package tpu_pkg;

  // Default systolic array dimension (N x N processing elements)
  localparam int N_DEFAULT  = 4;

  // Datapath word width: IEEE-754 single precision
  localparam int DATA_W     = 32;

  // Default width of the vector-count field (max 2^(KW-1) vectors per job)
  localparam int KW_DEFAULT = 9;

  // Controller states, in the order a normal job walks through them
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/skew_shreg.sv
// One-bit delay line of configurable depth. Used for every diagonal skew and
// array-latency delay in the systolic controller, so all timing offsets come
// from a single, uniformly behaving primitive.
module skew_shreg #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift the input one stage per clock; a synchronous clear empties the whole
  // line at once so a cancelled job leaves no stale valid pulses behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: loads one weight
// row per cycle into the PEs, streams k activation vectors, waits for the
// wavefront to drain out of the bottom of the array and pulses done.
module systolic_ctrl
  import tpu_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int KW = KW_DEFAULT,
  parameter int AW = 8
) (
  input  logic                 MCLK,
  input  logic                 RSTN,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd,
  output logic [$clog2(N)-1:0] w_addr,
  output logic [N-1:0]         pe_wen,
  output logic                 a_rd,
  output logic [AW-1:0]        a_addr,
  output logic [N-1:0]         x_valid,
  output logic [N-1:0]         o_valid
);

  localparam int WAW = $clog2(N);
  // Counter has to reach both the largest vector count and the 2N drain length
  localparam int CW  = (KW > $clog2(2*N) + 1) ? KW : $clog2(2*N) + 1;
  localparam logic [KW-1:0] KMAX = {1'b1, {(KW-1){1'b0}}};

  logic [1:0]     rstSync_q;
  logic           rstN;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  kLen_q, kLen_d;

  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           wRd_q, wRd_d;
  logic [WAW-1:0] wAddr_q, wAddr_d;
  logic [N-1:0]   peWen_q, peWen_d;
  logic           aRd_q, aRd_d;
  logic [AW-1:0]  aAddr_q, aAddr_d;
  logic           flush;

  // Larger requests are silently limited to the deepest job the buffer supports
  function automatic logic [KW-1:0] clampK(input logic [KW-1:0] k);
    if (k > KMAX) return KMAX;
    return k;
  endfunction

  // Reset asserts immediately but is released only on a clock edge, two flops deep
  always_ff @(posedge MCLK or negedge RSTN) begin
    if (!RSTN) rstSync_q <= 2'b00;
    else       rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstN  = rstSync_q[1];
  assign flush = abort && (state_q != IDLE);

  // Next-state, counter and next-output decode; abort from any busy state wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kLen_d  = kLen_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD_W;
            cnt_d   = '0;
            kLen_d  = clampK(k_len);
          end
        end
        LOAD_W: begin
          if (cnt_q == CW'(N)) begin
            cnt_d   = '0;
            state_d = (kLen_q == '0) ? DONE : STREAM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STREAM: begin
          if (cnt_q == CW'(kLen_q) - CW'(1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == CW'(2*N - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    wRd_d   = (state_d == LOAD_W) && (cnt_d < CW'(N));
    wAddr_d = wRd_d ? cnt_d[WAW-1:0] : '0;
    peWen_d = '1;
    for (int i = 0; i < N; i++) begin
      if ((state_d == LOAD_W) && (cnt_d == CW'(i + 1))) peWen_d[i] = 1'b0;
    end
    aRd_d   = (state_d == STREAM);
    aAddr_d = aRd_d ? AW'(cnt_d) : '0;
  end

  // Controller state and all of its outputs are registered together
  always_ff @(posedge MCLK or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kLen_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wRd_q   <= 1'b0;
      wAddr_q <= '0;
      peWen_q <= '1;
      aRd_q   <= 1'b0;
      aAddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kLen_q  <= kLen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wRd_q   <= wRd_d;
      wAddr_q <= wAddr_d;
      peWen_q <= peWen_d;
      aRd_q   <= aRd_d;
      aAddr_q <= aAddr_d;
    end
  end

  // Row r sees activations 1+r cycles after the buffer read (diagonal skew)
  for (genvar r = 0; r < N; r++) begin : gXSkew
    skew_shreg #(.DEPTH(1 + r)) uXSkew (
      .clk_i (MCLK),
      .rst_ni(rstN),
      .clr_i (flush),
      .d_i   (aRd_q),
      .q_o   (x_valid[r])
    );
  end

  // Column c results leave the array bottom N+1+c cycles after the read
  for (genvar c = 0; c < N; c++) begin : gOSkew
    skew_shreg #(.DEPTH(N + 1 + c)) uOSkew (
      .clk_i (MCLK),
      .rst_ni(rstN),
      .clr_i (flush),
      .d_i   (aRd_q),
      .q_o   (o_valid[c])
    );
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign w_rd   = wRd_q;
  assign w_addr = wAddr_q;
  assign pe_wen = peWen_q;
  assign a_rd   = aRd_q;
  assign a_addr = aAddr_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: each job pushes its cycle-by-cycle
// expected outputs into a scoreboard queue, and every cycle pops one entry
// and compares it with what the controller drives.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int KW = 9;
  localparam int AW = 8;

  logic          MCLK = 1'b0;
  logic          RSTN;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy;
  logic          done;
  logic          w_rd;
  logic [1:0]    w_addr;
  logic [N-1:0]  pe_wen;
  logic          a_rd;
  logic [AW-1:0] a_addr;
  logic [N-1:0]  x_valid;
  logic [N-1:0]  o_valid;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         wRd;
    logic [1:0]   wAddr;
    logic [N-1:0] peWen;
    logic         aRd;
    logic [7:0]   aAddr;
    logic [N-1:0] xValid;
    logic [N-1:0] oValid;
  } outs_t;

  localparam outs_t IDLE_OUTS = '{busy: 1'b0, done: 1'b0, wRd: 1'b0, wAddr: 2'd0,
                                  peWen: 4'hF, aRd: 1'b0, aAddr: 8'd0,
                                  xValid: 4'h0, oValid: 4'h0};

  outs_t expQ[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    aRdCount = 0;

  systolic_ctrl #(.N(N), .KW(KW), .AW(AW)) dut (
    .MCLK   (MCLK),
    .RSTN   (RSTN),
    .start  (start),
    .k_len  (k_len),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .w_rd   (w_rd),
    .w_addr (w_addr),
    .pe_wen (pe_wen),
    .a_rd   (a_rd),
    .a_addr (a_addr),
    .x_valid(x_valid),
    .o_valid(o_valid)
  );

  // Free-running 10-time-unit clock
  always #5 MCLK = ~MCLK;

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every controller output against one expected record
  task automatic checkAll(input outs_t e, input string where);
    checkOutput($sformatf("busy@%s", where),    32'(busy),    32'(e.busy));
    checkOutput($sformatf("done@%s", where),    32'(done),    32'(e.done));
    checkOutput($sformatf("w_rd@%s", where),    32'(w_rd),    32'(e.wRd));
    checkOutput($sformatf("w_addr@%s", where),  32'(w_addr),  32'(e.wAddr));
    checkOutput($sformatf("pe_wen@%s", where),  32'(pe_wen),  32'(e.peWen));
    checkOutput($sformatf("a_rd@%s", where),    32'(a_rd),    32'(e.aRd));
    checkOutput($sformatf("a_addr@%s", where),  32'(a_addr),  32'(e.aAddr));
    checkOutput($sformatf("x_valid@%s", where), 32'(x_valid), 32'(e.xValid));
    checkOutput($sformatf("o_valid@%s", where), 32'(o_valid), 32'(e.oValid));
  endtask

  // Sample on the falling edge against the scoreboard, then advance past the next rising edge
  task automatic stepCycle();
    outs_t e;
    @(negedge MCLK);
    e = IDLE_OUTS;
    if (expQ.size() > 0) e = expQ.pop_front();
    checkAll(e, $sformatf("%0d", cyc));
    if (a_rd === 1'b1) aRdCount++;
    cyc++;
    @(posedge MCLK);
    #1;
  endtask

  // Expected timeline of a whole job, offsets counted from the start cycle (t=0)
  function automatic void pushJob(input int kIn);
    int    kc;
    int    doneT;
    int    aFirst;
    int    aLast;
    outs_t e;
    kc     = (kIn > 256) ? 256 : kIn;
    doneT  = (kc == 0) ? N + 2 : N + 2 + kc + 2 * N;
    aFirst = N + 2;
    aLast  = N + 1 + kc;
    for (int t = 0; t <= doneT; t++) begin
      e      = IDLE_OUTS;
      e.busy = (t >= 1);
      e.done = (t == doneT);
      if (t >= 1 && t <= N) begin
        e.wRd   = 1'b1;
        e.wAddr = 2'(t - 1);
      end
      for (int i = 0; i < N; i++) begin
        if (t == 2 + i) e.peWen[i] = 1'b0;
      end
      if (kc > 0) begin
        if (t >= aFirst && t <= aLast) begin
          e.aRd   = 1'b1;
          e.aAddr = 8'(t - aFirst);
        end
        for (int r = 0; r < N; r++) begin
          if (t - 1 - r >= aFirst && t - 1 - r <= aLast) e.xValid[r] = 1'b1;
        end
        for (int c = 0; c < N; c++) begin
          if (t - (N + 1 + c) >= aFirst && t - (N + 1 + c) <= aLast) e.oValid[c] = 1'b1;
        end
      end
      expQ.push_back(e);
    end
  endfunction

  // Launch a job from IDLE; abortToo also raises abort in the start cycle
  task automatic applyStimulus(input int kIn, input logic abortToo);
    start = 1'b1;
    k_len = KW'(kIn);
    abort = abortToo;
    pushJob(kIn);
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Run until every expected entry has been compared, plus some idle slack
  task automatic runUntilIdle();
    while (expQ.size() > 0) stepCycle();
    repeat (3) stepCycle();
  endtask

  initial begin
    RSTN  = 1'b0;
    start = 1'b0;
    k_len = '0;
    abort = 1'b0;

    // Reset state, then release and let the internal synchroniser settle
    repeat (3) stepCycle();
    RSTN = 1'b1;
    repeat (4) stepCycle();

    // Reference job k=3 with the same cycle numbering as the design notes
    applyStimulus(3, 1'b0);
    runUntilIdle();

    // Zero-length job: weight load then straight to done
    applyStimulus(0, 1'b0);
    runUntilIdle();

    // Single-vector job, started with abort raised while still idle
    applyStimulus(1, 1'b1);
    runUntilIdle();

    // Abort alone in IDLE does nothing
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    stepCycle();

    // Abort in cycle 7 of a k=3 job: idle from cycle 8, no done pulse
    applyStimulus(3, 1'b0);
    repeat (6) stepCycle();
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    expQ.delete();
    repeat (14) stepCycle();
    applyStimulus(3, 1'b0);
    runUntilIdle();

    // Start seen during the DONE cycle must be dropped
    applyStimulus(2, 1'b0);
    while (expQ.size() > 1) stepCycle();
    start = 1'b1;
    k_len = KW'(5);
    stepCycle();
    start = 1'b0;
    repeat (4) stepCycle();

    // Reset pulse mid-STREAM: outputs return to reset values asynchronously
    applyStimulus(20, 1'b0);
    repeat (7) stepCycle();
    RSTN = 1'b0;
    #2;
    checkAll(IDLE_OUTS, "rst_async");
    expQ.delete();
    repeat (2) stepCycle();
    RSTN = 1'b1;
    repeat (4) stepCycle();

    // Oversized request is clamped; a second start during STREAM is ignored
    aRdCount = 0;
    applyStimulus(300, 1'b0);
    repeat (9) stepCycle();
    start = 1'b1;
    k_len = KW'(7);
    stepCycle();
    start = 1'b0;
    runUntilIdle();
    checkOutput("a_rd_total", 32'(aRdCount), 32'd256);

    // A few jobs with random lengths
    for (int j = 0; j < 3; j++) begin
      applyStimulus(int'($urandom_range(1, 12)), 1'b0);
      runUntilIdle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
